// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler: the tag that travels
// alongside each divide and the forced divide-by-zero quotient.
package div_sched_pkg;

    localparam int MAX_NREQ = 16;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(MAX_NREQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            dz;
    } tag_t;

    localparam logic [63:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr and then
// moves rr_ptr just past the winner; rr_ptr holds when nothing is granted.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          aclr_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          grant_any
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] idx;

    // NOTE: every output gets a default before the scan, so no path leaves one unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(rr_ptr) + k) % N);
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == LAST) ? '0 : grant_id + IW'(1);
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one fixed-latency pipelined divider among NREQ requesters: credit-gated
// round-robin issue, a tag pipe matching the divider latency, one-hot response pulses.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTHN  = 16,
    parameter int WIDTHD  = 16,
    parameter int DIV_LAT = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     clken,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTHN-1:0]   req_numer,
    input  logic [NREQ*WIDTHD-1:0]   req_denom,
    output logic [WIDTHN-1:0]        div_numer,
    output logic [WIDTHD-1:0]        div_denom,
    output logic                     div_clken,
    input  logic [WIDTHN-1:0]        div_quotient,
    input  logic [WIDTHD-1:0]        div_remain,
    output logic [NREQ-1:0]          resp_valid,
    output logic [WIDTHN-1:0]        resp_quotient,
    output logic [WIDTHD-1:0]        resp_remain,
    output logic                     resp_dz,
    output logic                     busy
);

    localparam int IW = id_width(NREQ);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    logic [NREQ-1:0][CW-1:0] outstanding;
    logic [NREQ-1:0]         eligible;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         dec;
    logic [IW-1:0]           grant_id;
    logic                    grant_any;
    tag_t                    tag_pipe [DIV_LAT];
    tag_t                    tag_last;
    logic                    resp_fire;
    logic [NREQ-1:0]         resp_valid_q;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (outstanding[i] < CNT_MAX) && clken;
        end
    end

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .clock     (clock),
        .aclr_n    (aclr_n),
        .req       (eligible),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign div_clken = clken;

    always_comb begin
        div_numer = '0;
        div_denom = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                div_numer = req_numer[i*WIDTHN +: WIDTHN];
                div_denom = req_denom[i*WIDTHD +: WIDTHD];
            end
        end
    end

    // NOTE: the tag pipe is reset in full because its valid bits decide which divider outputs are owned.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int s = 0; s < DIV_LAT; s++) tag_pipe[s] <= '0;
        end else if (clken) begin
            tag_pipe[0] <= '{valid: grant_any,
                             id:    ID_W'(grant_id),
                             dz:    grant_any && (div_denom == '0)};
            for (int s = 1; s < DIV_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign tag_last  = tag_pipe[DIV_LAT-1];
    assign resp_fire = clken && tag_last.valid;

    always_comb begin
        dec = '0;
        for (int i = 0; i < NREQ; i++) begin
            dec[i] = resp_fire && (tag_last.id == ID_W'(i));
        end
    end

    // A grant and a returning response on the same clock cancel out.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            outstanding <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && !dec[i]) begin
                    outstanding[i] <= outstanding[i] + CW'(1);
                end else if (dec[i] && !grant[i]) begin
                    outstanding[i] <= outstanding[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            resp_valid_q  <= '0;
            resp_quotient <= '0;
            resp_remain   <= '0;
            resp_dz       <= 1'b0;
        end else if (clken) begin
            resp_valid_q <= dec;
            if (tag_last.valid) begin
                resp_dz       <= tag_last.dz;
                resp_quotient <= tag_last.dz ? DZ_QUOTIENT[WIDTHN-1:0] : div_quotient;
                resp_remain   <= tag_last.dz ? '0 : div_remain;
            end
        end
    end

    // A pulse registered just before a freeze is held and shown once clken returns.
    assign resp_valid = resp_valid_q & {NREQ{clken}};

    // NOTE: blocking '=' accumulates inside combinational logic; registers above use '<=' only.
    always_comb begin
        busy = |resp_valid_q;
        for (int s = 0; s < DIV_LAT; s++) begin
            busy = busy | tag_pipe[s].valid;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_credit_chk
        assert property (@(posedge clock) disable iff (!aclr_n)
            !(dec[i] && !grant[i] && outstanding[i] == '0));
        assert property (@(posedge clock) disable iff (!aclr_n)
            !(grant[i] && !dec[i] && outstanding[i] == CNT_MAX));
    end

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model and a behavioural pipelined divider.
`timescale 1ns/1ps
module tb_div_scheduler;

    localparam int NREQ    = 4;
    localparam int WIDTHN  = 16;
    localparam int WIDTHD  = 16;
    localparam int DIV_LAT = 4;
    localparam int MAX_OUT = 2;

    logic                   clock     = 1'b0;
    logic                   aclr_n    = 1'b1;
    logic                   clken     = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WIDTHN-1:0] req_numer = '0;
    logic [NREQ*WIDTHD-1:0] req_denom = '0;
    logic [WIDTHN-1:0]      div_numer;
    logic [WIDTHD-1:0]      div_denom;
    logic                   div_clken;
    logic [WIDTHN-1:0]      div_quotient;
    logic [WIDTHD-1:0]      div_remain;
    logic [NREQ-1:0]        resp_valid;
    logic [WIDTHN-1:0]      resp_quotient;
    logic [WIDTHD-1:0]      resp_remain;
    logic                   resp_dz;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    div_scheduler #(
        .NREQ(NREQ), .WIDTHN(WIDTHN), .WIDTHD(WIDTHD), .DIV_LAT(DIV_LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .clock(clock), .aclr_n(aclr_n), .clken(clken),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_numer(req_numer), .req_denom(req_denom),
        .div_numer(div_numer), .div_denom(div_denom), .div_clken(div_clken),
        .div_quotient(div_quotient), .div_remain(div_remain),
        .resp_valid(resp_valid), .resp_quotient(resp_quotient), .resp_remain(resp_remain),
        .resp_dz(resp_dz), .busy(busy)
    );

    // Behavioural divider: DIV_LAT enabled clocks from operands to result; garbage on /0.
    logic [WIDTHN-1:0] dn [DIV_LAT] = '{default: '0};
    logic [WIDTHD-1:0] dd [DIV_LAT] = '{default: '0};
    always @(posedge clock) begin
        if (div_clken) begin
            dn[0] <= div_numer;
            dd[0] <= div_denom;
            for (int s = 1; s < DIV_LAT; s++) begin
                dn[s] <= dn[s-1];
                dd[s] <= dd[s-1];
            end
        end
    end
    assign div_quotient = (dd[DIV_LAT-1] == '0) ? 16'hDEAD : dn[DIV_LAT-1] / dd[DIV_LAT-1];
    assign div_remain   = (dd[DIV_LAT-1] == '0) ? 16'hBEEF : dn[DIV_LAT-1] % dd[DIV_LAT-1];

    // Reference model: in-flight ops in a queue, each due a fixed number of enabled clocks later.
    typedef struct {
        int          id;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        longint      due;
    } op_t;

    op_t             m_q[$];
    int              m_rr = 0;
    int              m_out [NREQ] = '{default: 0};
    longint          m_ecount = 0;
    logic [NREQ-1:0] m_resp_valid = '0;
    logic [15:0]     m_resp_q = '0;
    logic [15:0]     m_resp_r = '0;
    logic            m_resp_dz = 1'b0;

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (clken && req_valid[i] && m_out[i] < MAX_OUT) return i;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            m_q.delete();
            m_rr = 0;
            for (int i = 0; i < NREQ; i++) m_out[i] = 0;
            m_resp_valid = '0;
            m_resp_q = '0;
            m_resp_r = '0;
            m_resp_dz = 1'b0;
        end else if (clken) begin
            int g;
            op_t op;
            logic [15:0] n, d;
            g = model_grant();
            m_ecount++;
            m_resp_valid = '0;
            if (m_q.size() > 0 && m_q[0].due == m_ecount) begin
                op = m_q.pop_front();
                m_resp_valid[op.id] = 1'b1;
                m_resp_q  = op.q;
                m_resp_r  = op.r;
                m_resp_dz = op.dz;
                m_out[op.id]--;
            end
            if (g >= 0) begin
                n = req_numer[g*WIDTHN +: WIDTHN];
                d = req_denom[g*WIDTHD +: WIDTHD];
                op.id  = g;
                op.dz  = (d == 0);
                op.q   = op.dz ? 16'hFFFF : n / d;
                op.r   = op.dz ? 16'h0000 : n % d;
                op.due = m_ecount + DIV_LAT;
                m_q.push_back(op);
                m_out[g]++;
                m_rr = (g + 1) % NREQ;
            end
        end
    end

    // Per-cycle monitor, sampled on the falling edge.
    always @(negedge clock) begin
        int g;
        logic [NREQ-1:0] e_ready;
        logic [15:0]     e_n, e_d;
        logic            e_busy;
        g = model_grant();
        e_ready = '0;
        e_n = '0;
        e_d = '0;
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_n = req_numer[g*WIDTHN +: WIDTHN];
            e_d = req_denom[g*WIDTHD +: WIDTHD];
        end
        e_busy = (m_q.size() != 0) || (m_resp_valid != '0);

        checks++;
        if (req_ready !== e_ready) begin
            errors++; $display("FAIL mon_req_ready t=%0t got %b expected %b", $time, req_ready, e_ready);
        end
        checks++;
        if (div_numer !== e_n || div_denom !== e_d) begin
            errors++; $display("FAIL mon_operands t=%0t got %h/%h expected %h/%h", $time, div_numer, div_denom, e_n, e_d);
        end
        checks++;
        if (div_clken !== clken) begin
            errors++; $display("FAIL mon_div_clken t=%0t got %b expected %b", $time, div_clken, clken);
        end
        checks++;
        if (resp_valid !== (m_resp_valid & {NREQ{clken}})) begin
            errors++; $display("FAIL mon_resp_valid t=%0t got %b expected %b", $time, resp_valid, m_resp_valid & {NREQ{clken}});
        end
        checks++;
        if (resp_quotient !== m_resp_q || resp_remain !== m_resp_r || resp_dz !== m_resp_dz) begin
            errors++; $display("FAIL mon_resp_data t=%0t got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                               $time, resp_quotient, resp_remain, resp_dz, m_resp_q, m_resp_r, m_resp_dz);
        end
        checks++;
        if (busy !== e_busy) begin
            errors++; $display("FAIL mon_busy t=%0t got %b expected %b", $time, busy, e_busy);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        clken = 1'b1;
        repeat (12) tick();
    endtask

    task automatic set_op(input int i, input logic [15:0] n, input logic [15:0] d);
        req_numer[i*WIDTHN +: WIDTHN] = n;
        req_denom[i*WIDTHD +: WIDTHD] = d;
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (resp_valid !== '0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        aclr_n = 1'b0;
        tick();
        aclr_n = 1'b1;
    endtask

    task automatic test_reset();
        aclr_n = 1'b0;
        clken = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        @(negedge clock);
        checks++;
        if ({resp_valid, resp_quotient, resp_remain, resp_dz, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs got rv=%b q=%h r=%h dz=%b busy=%b expected all zero",
                               resp_valid, resp_quotient, resp_remain, resp_dz, busy);
        end
        tick();
        aclr_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int lat;
        set_op(2, 16'd100, 16'd7);
        req_valid = 4'b0100;
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        wait_resp(lat);
        checks++;
        if (lat != 5) begin
            errors++; $display("FAIL single_latency got %0d expected 5", lat);
        end
        checks++;
        if (resp_valid !== 4'b0100 || resp_quotient !== 16'd14 || resp_remain !== 16'd2 || resp_dz !== 1'b0) begin
            errors++; $display("FAIL single_resp got rv=%b q=%0d r=%0d dz=%b expected 0100 14 2 0",
                               resp_valid, resp_quotient, resp_remain, resp_dz);
        end
        tick();
        drain();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] e;
        bit skip_pat [8] = '{1, 1, 0, 0, 0, 1, 1, 0};
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom_range(1, 300)));
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            e = 4'b0001 << (c % 4);
            @(negedge clock);
            checks++;
            if (req_ready !== e) begin
                errors++; $display("FAIL rr_order cycle %0d got %b expected %b", c, req_ready, e);
            end
            tick();
        end
        drain();
        req_valid = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            e = skip_pat[c] ? 4'b0001 : 4'b0000;
            @(negedge clock);
            checks++;
            if (req_ready !== e) begin
                errors++; $display("FAIL credit_skip cycle %0d got %b expected %b", c, req_ready, e);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_divide_by_zero();
        int lat;
        set_op(1, 16'd55, 16'd0);
        req_valid = 4'b0010;
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL dz_ready got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        wait_resp(lat);
        checks++;
        if (lat != 5 || resp_valid !== 4'b0010 || resp_dz !== 1'b1 || resp_quotient !== 16'hFFFF || resp_remain !== 16'h0) begin
            errors++; $display("FAIL dz_resp got lat=%0d rv=%b dz=%b q=%h r=%h expected 5 0010 1 ffff 0000",
                               lat, resp_valid, resp_dz, resp_quotient, resp_remain);
        end
        tick();
        drain();
    endtask

    task automatic test_clken_freeze();
        int lat;
        lat = -1;
        set_op(0, 16'd100, 16'd7);
        req_valid = 4'b0001;
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL freeze_ready got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        for (int k = 1; k <= 20; k++) begin
            clken = !(k >= 2 && k <= 4);
            @(negedge clock);
            if (!clken) begin
                checks++;
                if (resp_valid !== '0) begin
                    errors++; $display("FAIL freeze_quiet cycle %0d got %b expected 0000", k, resp_valid);
                end
            end
            if (resp_valid !== '0) begin
                lat = k;
                break;
            end
            tick();
        end
        clken = 1'b1;
        checks++;
        if (lat != 8 || resp_valid !== 4'b0001 || resp_quotient !== 16'd14 || resp_remain !== 16'd2 || resp_dz !== 1'b0) begin
            errors++; $display("FAIL freeze_resp got lat=%0d rv=%b q=%0d r=%0d dz=%b expected 8 0001 14 2 0",
                               lat, resp_valid, resp_quotient, resp_remain, resp_dz);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_midflight();
        for (int i = 1; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom_range(1, 50)));
        req_valid = 4'b1110;
        repeat (3) tick();
        req_valid = '0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midflight_busy got %b expected 1", busy);
        end
        tick();
        aclr_n = 1'b0;
        repeat (2) tick();
        aclr_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checks++;
            if (resp_valid !== '0 || busy !== 1'b0) begin
                errors++; $display("FAIL flushed_quiet cycle %0d got rv=%b busy=%b expected 0000 0", k, resp_valid, busy);
            end
            tick();
        end
        req_valid = '1;
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL post_reset_first got %b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (req_ready !== 4'b0010) begin
                errors++; $display("FAIL post_reset_credit %0d got %b expected 0010", c, req_ready);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_same_clock();
        set_op(3, 16'd200, 16'd9);
        req_valid = 4'b1000;
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL same_first got %b expected 1000", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
        req_valid = 4'b1000;
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL same_edge_grant got %b expected 1000", req_ready);
        end
        tick();
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b1000 || resp_valid !== 4'b1000 || resp_quotient !== 16'd22 || resp_remain !== 16'd2) begin
            errors++; $display("FAIL same_still_eligible got ready=%b rv=%b q=%0d r=%0d expected 1000 1000 22 2",
                               req_ready, resp_valid, resp_quotient, resp_remain);
        end
        tick();
        @(negedge clock);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL same_credit_full got %b expected 0000", req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                set_op(i, 16'($urandom), ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
            end
            clken  = ($urandom_range(0, 9) != 0);
            aclr_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        aclr_n = 1'b1;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_divide_by_zero();
        test_clken_freeze();
        test_reset_midflight();
        test_same_clock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
